// File: rtl/rpn_pkg.sv
// Shared opcode encodings and sizing helper for the RPN stack engine.
package rpn_pkg;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_MUL   = 3'd2;
  localparam logic [2:0] OP_DUP   = 3'd3;
  localparam logic [2:0] OP_SWAP  = 3'd4;
  localparam logic [2:0] OP_DROP  = 3'd5;
  localparam logic [2:0] OP_NEG   = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  // Bits needed to count 0..d entries inclusive.
  function automatic int depth_w(input int d);
    return $clog2(d + 1);
  endfunction

endpackage

// File: rtl/rpn_alu.sv
// Combinational ALU: a is the second-from-top entry, b is the top entry.
// Result is always truncated to WIDTH; ovf flags a non-representable result.
module rpn_alu import rpn_pkg::*; #(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  logic [WIDTH:0]     sum, dif;
  logic [2*WIDTH-1:0] ax, bx, prod;
  logic [WIDTH-1:0]   neg;

  // Operands are extended to 2W first, so the low 2W bits of the product
  // are the exact signed or unsigned product depending on the extension.
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    dif  = {1'b0, a} - {1'b0, b};
    neg  = '0 - b;
    ax   = (SIGNED != 0) ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    bx   = (SIGNED != 0) ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    prod = ax * bx;
    result = b;
    ovf    = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        ovf    = (SIGNED != 0) ? ((a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]))
                               : sum[WIDTH];
      end
      OP_SUB: begin
        result = dif[WIDTH-1:0];
        ovf    = (SIGNED != 0) ? ((a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]))
                               : dif[WIDTH];
      end
      OP_MUL: begin
        result = prod[WIDTH-1:0];
        ovf    = (SIGNED != 0) ? (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                               : (|prod[2*WIDTH-1:WIDTH]);
      end
      OP_NEG: begin
        result = neg;
        ovf    = (SIGNED != 0) ? (b == {1'b1, {(WIDTH-1){1'b0}}}) : (|b);
      end
      default: begin
        result = b;
        ovf    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rpn_stack_core.sv
// RPN evaluation engine: DEPTH x WIDTH stack, legality checks, sticky errors.
// top/next/flags are registered from next-state so they track the stack exactly.
module rpn_stack_core import rpn_pkg::*; #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int SIGNED = 1
) (
  input  logic                        CLOCK_50,
  input  logic                        rst_n,
  input  logic                        push_valid,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        op_valid,
  input  logic [2:0]                  op_code,
  output logic                        done,
  output logic [WIDTH-1:0]            top,
  output logic [WIDTH-1:0]            next,
  output logic [depth_w(DEPTH)-1:0]   depth,
  output logic                        empty,
  output logic                        full,
  output logic                        err_ovf,
  output logic                        err_unf,
  output logic                        err_arith,
  output logic                        err_cmd
);

  localparam int DW = depth_w(DEPTH);
  localparam int IW = $clog2(DEPTH);
  localparam logic [DW-1:0] D_ONE  = DW'(1);
  localparam logic [DW-1:0] D_TWO  = DW'(2);
  localparam logic [DW-1:0] D_FULL = DW'(DEPTH);

  logic                        rst_q;
  logic [DEPTH-1:0][WIDTH-1:0] stk_q, stk_d;
  logic [DW-1:0]               depth_q, depth_d;
  logic [WIDTH-1:0]            top_q, top_d, next_q, next_d;
  logic                        empty_q, empty_d, full_q, full_d, done_q;
  logic                        eo_q, eo_d, eu_q, eu_d, ea_q, ea_d, ec_q, ec_d;
  logic [IW-1:0]               i0, i1, i2, di1, di2;
  logic                        has1, has2;
  logic [WIDTH-1:0]            alu_res;
  logic                        alu_ovf;

  rpn_alu #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_alu (
    .a(next_q), .b(top_q), .op(op_code), .result(alu_res), .ovf(alu_ovf)
  );

  // Reset asserts immediately but releases one edge late, so a strobe
  // arriving on the release edge is dropped.
  always_ff @(posedge CLOCK_50 or negedge rst_n)
    if (!rst_n) rst_q <= 1'b0;
    else        rst_q <= 1'b1;

  // Command decode: legality checks, stack update, sticky error flags.
  always_comb begin
    i0   = IW'(depth_q);
    i1   = IW'(depth_q - D_ONE);
    i2   = IW'(depth_q - D_TWO);
    has1 = (depth_q != '0);
    has2 = (depth_q >= D_TWO);
    stk_d   = stk_q;
    depth_d = depth_q;
    eo_d = eo_q; eu_d = eu_q; ea_d = ea_q; ec_d = ec_q;
    if (push_valid && op_valid) begin
      ec_d = 1'b1;
    end else if (push_valid) begin
      if (depth_q == D_FULL) eo_d = 1'b1;
      else begin
        stk_d[i0] = push_data;
        depth_d   = depth_q + D_ONE;
      end
    end else if (op_valid) begin
      case (op_code)
        OP_ADD, OP_SUB, OP_MUL: begin
          if (!has2) eu_d = 1'b1;
          else begin
            stk_d[i2] = alu_res;
            depth_d   = depth_q - D_ONE;
            if (alu_ovf) ea_d = 1'b1;
          end
        end
        OP_SWAP: begin
          if (!has2) eu_d = 1'b1;
          else begin
            stk_d[i1] = next_q;
            stk_d[i2] = top_q;
          end
        end
        OP_DUP: begin
          if (!has1) eu_d = 1'b1;
          else if (depth_q == D_FULL) eo_d = 1'b1;
          else begin
            stk_d[i0] = top_q;
            depth_d   = depth_q + D_ONE;
          end
        end
        OP_DROP: begin
          if (!has1) eu_d = 1'b1;
          else depth_d = depth_q - D_ONE;
        end
        OP_NEG: begin
          if (!has1) eu_d = 1'b1;
          else begin
            stk_d[i1] = alu_res;
            if (alu_ovf) ea_d = 1'b1;
          end
        end
        default: begin
          // CLEAR: always legal, also wipes the error history
          depth_d = '0;
          eo_d = 1'b0; eu_d = 1'b0; ea_d = 1'b0; ec_d = 1'b0;
        end
      endcase
    end
  end

  // Derive the visible window from the post-update stack.
  always_comb begin
    di1     = IW'(depth_d - D_ONE);
    di2     = IW'(depth_d - D_TWO);
    top_d   = (depth_d != '0)    ? stk_d[di1] : '0;
    next_d  = (depth_d >= D_TWO) ? stk_d[di2] : '0;
    empty_d = (depth_d == '0);
    full_d  = (depth_d == D_FULL);
  end

  // State and registered outputs.
  always_ff @(posedge CLOCK_50 or negedge rst_q) begin
    if (!rst_q) begin
      stk_q   <= '0;
      depth_q <= '0;
      top_q   <= '0;
      next_q  <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      done_q  <= 1'b0;
      eo_q <= 1'b0; eu_q <= 1'b0; ea_q <= 1'b0; ec_q <= 1'b0;
    end else begin
      stk_q   <= stk_d;
      depth_q <= depth_d;
      top_q   <= top_d;
      next_q  <= next_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      done_q  <= push_valid | op_valid;
      eo_q <= eo_d; eu_q <= eu_d; ea_q <= ea_d; ec_q <= ec_d;
    end
  end

  assign done      = done_q;
  assign top       = top_q;
  assign next      = next_q;
  assign depth     = depth_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign err_ovf   = eo_q;
  assign err_unf   = eu_q;
  assign err_arith = ea_q;
  assign err_cmd   = ec_q;

endmodule

// File: tb/tb_rpn_stack_core.sv
// Scoreboard bench: strobes queue an expected snapshot, monitors compare on done.
// u0: WIDTH=8 DEPTH=4 SIGNED=1, u1: WIDTH=8 DEPTH=4 SIGNED=0.
module tb_rpn_stack_core;
  import rpn_pkg::*;

  typedef struct packed {
    logic [7:0] top;
    logic [7:0] nxt;
    logic [2:0] dep;
    logic emp, ful, ovf, unf, ari, cmd;
  } exp_t;

  logic CLOCK_50 = 1'b0;
  logic rst_n = 1'b0;
  logic pv0 = 0, ov0 = 0, pv1 = 0, ov1 = 0;
  logic [7:0] pd0 = 0, pd1 = 0;
  logic [2:0] oc0 = 0, oc1 = 0;
  logic done0, done1, emp0, emp1, ful0, ful1;
  logic eo0, eu0, ea0, ec0, eo1, eu1, ea1, ec1;
  logic [7:0] top0, top1, nxt0, nxt1;
  logic [2:0] dep0, dep1;

  int n_tests = 0, n_fail = 0;
  exp_t q0[$], q1[$];
  int id0[$], id1[$];

  always #5 CLOCK_50 = ~CLOCK_50;

  rpn_stack_core #(.WIDTH(8), .DEPTH(4), .SIGNED(1)) u0 (
    .CLOCK_50(CLOCK_50), .rst_n(rst_n), .push_valid(pv0), .push_data(pd0),
    .op_valid(ov0), .op_code(oc0), .done(done0), .top(top0), .next(nxt0),
    .depth(dep0), .empty(emp0), .full(ful0), .err_ovf(eo0), .err_unf(eu0),
    .err_arith(ea0), .err_cmd(ec0));

  rpn_stack_core #(.WIDTH(8), .DEPTH(4), .SIGNED(0)) u1 (
    .CLOCK_50(CLOCK_50), .rst_n(rst_n), .push_valid(pv1), .push_data(pd1),
    .op_valid(ov1), .op_code(oc1), .done(done1), .top(top1), .next(nxt1),
    .depth(dep1), .empty(emp1), .full(ful1), .err_ovf(eo1), .err_unf(eu1),
    .err_arith(ea1), .err_cmd(ec1));

  function automatic exp_t mk(input logic [7:0] t, input logic [7:0] n, input logic [2:0] d,
                              input logic o, input logic u, input logic a, input logic c);
    exp_t e;
    e.top = t; e.nxt = n; e.dep = d;
    e.emp = (d == 3'd0); e.ful = (d == 3'd4);
    e.ovf = o; e.unf = u; e.ari = a; e.cmd = c;
    return e;
  endfunction

  function automatic exp_t obs0();
    return {top0, nxt0, dep0, emp0, ful0, eo0, eu0, ea0, ec0};
  endfunction

  function automatic exp_t obs1();
    return {top1, nxt1, dep1, emp1, ful1, eo1, eu1, ea1, ec1};
  endfunction

  task automatic cmp(input int id, input exp_t g, input exp_t w);
    n_tests++;
    if (g !== w) begin
      n_fail++;
      $display("FAIL step %0d: got top=%h next=%h depth=%0d empty=%b full=%b ovf/unf/arith/cmd=%b%b%b%b, want top=%h next=%h depth=%0d empty=%b full=%b ovf/unf/arith/cmd=%b%b%b%b",
               id, g.top, g.nxt, g.dep, g.emp, g.ful, g.ovf, g.unf, g.ari, g.cmd,
               w.top, w.nxt, w.dep, w.emp, w.ful, w.ovf, w.unf, w.ari, w.cmd);
    end
  endtask

  task automatic chk_bit(input string name, input logic got, input logic want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  // Monitors: every done pulse must match the oldest outstanding expectation.
  always @(negedge CLOCK_50) begin
    if (done0 === 1'b1) begin
      if (q0.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL u0 unexpected done: got done=1 want no pulse");
      end else cmp(id0.pop_front(), obs0(), q0.pop_front());
    end
    if (done1 === 1'b1) begin
      if (q1.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL u1 unexpected done: got done=1 want no pulse");
      end else cmp(id1.pop_front(), obs1(), q1.pop_front());
    end
  end

  // Issue one strobe cycle; called at posedge+1.
  task automatic strobe(input bit s, input logic pv, input logic ov, input logic [7:0] d,
                        input logic [2:0] oc, input exp_t e, input int id);
    if (!s) begin
      pv0 = pv; ov0 = ov; pd0 = d; oc0 = oc;
      q0.push_back(e); id0.push_back(id);
    end else begin
      pv1 = pv; ov1 = ov; pd1 = d; oc1 = oc;
      q1.push_back(e); id1.push_back(id);
    end
    @(posedge CLOCK_50); #1;
    pv0 = 0; ov0 = 0; pv1 = 0; ov1 = 0;
  endtask

  task automatic push(input bit s, input logic [7:0] d, input exp_t e, input int id);
    strobe(s, 1'b1, 1'b0, d, 3'd0, e, id);
  endtask

  task automatic op(input bit s, input logic [2:0] oc, input exp_t e, input int id);
    strobe(s, 1'b0, 1'b1, 8'h00, oc, e, id);
  endtask

  initial begin
    repeat (2) @(posedge CLOCK_50);
    #1;
    cmp(0, obs0(), mk(8'h00, 8'h00, 3'd0, 0, 0, 0, 0));
    cmp(100, obs1(), mk(8'h00, 8'h00, 3'd0, 0, 0, 0, 0));
    chk_bit("reset done u0", done0, 1'b0);
    @(negedge CLOCK_50); rst_n = 1'b1;
    @(posedge CLOCK_50); #1;

    // Basic add
    push(0, 8'd41, mk(8'd41, 8'd0, 3'd1, 0, 0, 0, 0), 1);
    push(0, 8'd5,  mk(8'd5, 8'd41, 3'd2, 0, 0, 0, 0), 2);
    op(0, OP_ADD,  mk(8'd46, 8'd0, 3'd1, 0, 0, 0, 0), 3);
    // Signed overflow on add, then CLEAR
    push(0, 8'd100, mk(8'd100, 8'd46, 3'd2, 0, 0, 0, 0), 4);
    push(0, 8'd50,  mk(8'd50, 8'd100, 3'd3, 0, 0, 0, 0), 5);
    op(0, OP_ADD,   mk(8'h96, 8'd46, 3'd2, 0, 0, 1, 0), 6);
    op(0, OP_CLEAR, mk(8'h00, 8'h00, 3'd0, 0, 0, 0, 0), 7);
    // Fill, push when full, SWAP, SUB
    push(0, 8'd1, mk(8'd1, 8'd0, 3'd1, 0, 0, 0, 0), 8);
    push(0, 8'd2, mk(8'd2, 8'd1, 3'd2, 0, 0, 0, 0), 9);
    push(0, 8'd3, mk(8'd3, 8'd2, 3'd3, 0, 0, 0, 0), 10);
    push(0, 8'd4, mk(8'd4, 8'd3, 3'd4, 0, 0, 0, 0), 11);
    push(0, 8'd9, mk(8'd4, 8'd3, 3'd4, 1, 0, 0, 0), 12);
    op(0, OP_SWAP,  mk(8'd3, 8'd4, 3'd4, 1, 0, 0, 0), 13);
    op(0, OP_SUB,   mk(8'd1, 8'd2, 3'd3, 1, 0, 0, 0), 14);
    op(0, OP_CLEAR, mk(8'd0, 8'd0, 3'd0, 0, 0, 0, 0), 15);
    // Underflow, DUP, MUL, NEG, DROP
    op(0, OP_ADD,  mk(8'd0, 8'd0, 3'd0, 0, 1, 0, 0), 16);
    push(0, 8'd7,  mk(8'd7, 8'd0, 3'd1, 0, 1, 0, 0), 17);
    op(0, OP_DUP,  mk(8'd7, 8'd7, 3'd2, 0, 1, 0, 0), 18);
    op(0, OP_MUL,  mk(8'd49, 8'd0, 3'd1, 0, 1, 0, 0), 19);
    op(0, OP_NEG,  mk(8'hCF, 8'd0, 3'd1, 0, 1, 0, 0), 20);
    op(0, OP_DROP, mk(8'd0, 8'd0, 3'd0, 0, 1, 0, 0), 21);
    // Push and op together
    strobe(0, 1'b1, 1'b1, 8'd3, OP_ADD, mk(8'd0, 8'd0, 3'd0, 0, 1, 0, 1), 22);
    op(0, OP_CLEAR, mk(8'd0, 8'd0, 3'd0, 0, 0, 0, 0), 23);
    // NEG of most-negative, MUL overflow
    push(0, 8'h80,  mk(8'h80, 8'd0, 3'd1, 0, 0, 0, 0), 24);
    op(0, OP_NEG,   mk(8'h80, 8'd0, 3'd1, 0, 0, 1, 0), 25);
    op(0, OP_CLEAR, mk(8'd0, 8'd0, 3'd0, 0, 0, 0, 0), 26);
    push(0, 8'h10,  mk(8'h10, 8'd0, 3'd1, 0, 0, 0, 0), 27);
    push(0, 8'h10,  mk(8'h10, 8'h10, 3'd2, 0, 0, 0, 0), 28);
    op(0, OP_MUL,   mk(8'h00, 8'd0, 3'd1, 0, 0, 1, 0), 29);
    op(0, OP_CLEAR, mk(8'd0, 8'd0, 3'd0, 0, 0, 0, 0), 30);
    // DUP when full
    push(0, 8'd1, mk(8'd1, 8'd0, 3'd1, 0, 0, 0, 0), 31);
    push(0, 8'd2, mk(8'd2, 8'd1, 3'd2, 0, 0, 0, 0), 32);
    push(0, 8'd3, mk(8'd3, 8'd2, 3'd3, 0, 0, 0, 0), 33);
    push(0, 8'd4, mk(8'd4, 8'd3, 3'd4, 0, 0, 0, 0), 34);
    op(0, OP_DUP,   mk(8'd4, 8'd3, 3'd4, 1, 0, 0, 0), 35);
    op(0, OP_CLEAR, mk(8'd0, 8'd0, 3'd0, 0, 0, 0, 0), 36);
    // Reset asserted between edges
    push(0, 8'd12, mk(8'd12, 8'd0, 3'd1, 0, 0, 0, 0), 37);
    push(0, 8'd13, mk(8'd13, 8'd12, 3'd2, 0, 0, 0, 0), 38);
    @(negedge CLOCK_50); #1;
    rst_n = 1'b0;
    #1;
    cmp(39, obs0(), mk(8'd0, 8'd0, 3'd0, 0, 0, 0, 0));
    chk_bit("mid-reset done u0", done0, 1'b0);
    @(negedge CLOCK_50); rst_n = 1'b1;
    @(posedge CLOCK_50); #1;

    // Unsigned instance
    push(1, 8'd200, mk(8'd200, 8'd0, 3'd1, 0, 0, 0, 0), 101);
    push(1, 8'd100, mk(8'd100, 8'd200, 3'd2, 0, 0, 0, 0), 102);
    op(1, OP_ADD,   mk(8'd44, 8'd0, 3'd1, 0, 0, 1, 0), 103);
    op(1, OP_NEG,   mk(8'hD4, 8'd0, 3'd1, 0, 0, 1, 0), 104);
    op(1, OP_CLEAR, mk(8'd0, 8'd0, 3'd0, 0, 0, 0, 0), 105);
    push(1, 8'd1,   mk(8'd1, 8'd0, 3'd1, 0, 0, 0, 0), 106);
    push(1, 8'd2,   mk(8'd2, 8'd1, 3'd2, 0, 0, 0, 0), 107);
    op(1, OP_SUB,   mk(8'hFF, 8'd0, 3'd1, 0, 0, 1, 0), 108);

    repeat (3) @(posedge CLOCK_50);
    #1;
    n_tests++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL missing done: got %0d/%0d expectations outstanding want 0/0", q0.size(), q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
